// File: rtl/mem_axi_bridge_pkg.sv
// Shared definitions for the mem_to_axi_bridge: op types, AXI code constants,
// issue-stage states and the AXI size helper.
package mem_axi_bridge_pkg;

    // Operation type stored in the tracking FIFO (bit value is s_mem_we).
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } op_e;

    // AXI burst and response codes.
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Fixed cache attribute: bufferable + modifiable.
    localparam logic [3:0] AXI_CACHE_ATTR = 4'b0011;

    // Issue stage: AWW means both AW and W still pending.
    typedef enum logic [2:0] {
        ISSUE_IDLE = 3'd0,
        ISSUE_AR   = 3'd1,
        ISSUE_AWW  = 3'd2,
        ISSUE_AW   = 3'd3,
        ISSUE_W    = 3'd4
    } issue_state_e;

    // AXI size code for a full-width beat (32 -> 2, 64 -> 3).
    function automatic logic [2:0] axi_size(input int data_width);
        return (data_width == 64) ? 3'd3 : 3'd2;
    endfunction

endpackage

// File: rtl/bridge_track_fifo.sv
// Tracking FIFO for outstanding requests. DEPTH must be a power of two so the
// pointers wrap naturally; the caller never pushes when full or pops when empty.
module bridge_track_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Pointer and occupancy bookkeeping; push+pop together keeps count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty is tracked by count alone.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mem_to_axi_bridge.sv
// Core memory-port to AXI4 bridge. One request in the issue stage at a time,
// up to MAX_OUTSTANDING responses tracked in order, single-beat transfers only.
// Optional error capture is compiled in with MEM_AXI_BRIDGE_ERR_CAPTURE_EN.
module mem_to_axi_bridge
    import mem_axi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 6,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    s_mem_req,
    output logic                    s_mem_gnt,
    input  logic [ADDR_WIDTH-1:0]   s_mem_addr,
    input  logic                    s_mem_we,
    input  logic [DATA_WIDTH/8-1:0] s_mem_be,
    input  logic [DATA_WIDTH-1:0]   s_mem_wdata,
    output logic                    s_mem_valid,
    output logic [DATA_WIDTH-1:0]   s_mem_rdata,
    output logic                    s_mem_error,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awqos,
    output logic [3:0]              m_axi_awregion,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arqos,
    output logic [3:0]              m_axi_arregion,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic                    m_axi_rlast,
    output logic                    err_irq_o,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    input  logic                    err_clr_i
);
    localparam logic [2:0] AXI_SIZE = axi_size(DATA_WIDTH);

    // Handshake rule on every channel: a transfer happens on a rising edge
    // where valid and ready are both high; valid, once raised, holds its
    // payload stable until that edge; ready never waits on valid.

    issue_state_e state;
    issue_state_e state_next;

    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ADDR_WIDTH:0]     fifo_head;
    op_e                     head_op;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic                    r_hs;
    logic                    b_hs;
    logic                    rsp_pop;

    // Acceptance: idle issue stage and room to track the response.
    assign s_mem_gnt = rst_ni & s_mem_req & (state == ISSUE_IDLE) & ~fifo_full;

    // Issue-stage state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ISSUE_IDLE;
        else         state <= state_next;
    end

    // Issue-stage next state: AW and W retire independently.
    always_comb begin
        state_next = state;
        case (state)
            ISSUE_IDLE: if (s_mem_gnt) state_next = s_mem_we ? ISSUE_AWW : ISSUE_AR;
            ISSUE_AR:   if (m_axi_arready) state_next = ISSUE_IDLE;
            ISSUE_AWW: begin
                if (m_axi_awready && m_axi_wready) state_next = ISSUE_IDLE;
                else if (m_axi_awready)            state_next = ISSUE_W;
                else if (m_axi_wready)             state_next = ISSUE_AW;
            end
            ISSUE_AW:   if (m_axi_awready) state_next = ISSUE_IDLE;
            ISSUE_W:    if (m_axi_wready)  state_next = ISSUE_IDLE;
            default:    state_next = ISSUE_IDLE;
        endcase
    end

    // Issue-stage outputs: channel valids decoded from state.
    always_comb begin
        m_axi_arvalid = (state == ISSUE_AR);
        m_axi_awvalid = (state == ISSUE_AWW) || (state == ISSUE_AW);
        m_axi_wvalid  = (state == ISSUE_AWW) || (state == ISSUE_W);
    end

    // Capture request payload at acceptance; held while the issue stage is busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
        end else if (s_mem_gnt) begin
            req_addr  <= s_mem_addr;
            req_wdata <= s_mem_wdata;
            req_be    <= s_mem_be;
        end
    end

    assign m_axi_awaddr   = req_addr;
    assign m_axi_awid     = '0;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = AXI_SIZE;
    assign m_axi_awburst  = AXI_BURST_INCR;
    assign m_axi_awcache  = AXI_CACHE_ATTR;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_wdata    = req_wdata;
    assign m_axi_wstrb    = req_be;
    assign m_axi_wlast    = 1'b1;
    assign m_axi_araddr   = req_addr;
    assign m_axi_arid     = '0;
    assign m_axi_arlen    = 8'd0;
    assign m_axi_arsize   = AXI_SIZE;
    assign m_axi_arburst  = AXI_BURST_INCR;
    assign m_axi_arcache  = AXI_CACHE_ATTR;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;

    bridge_track_fifo #(
        .WIDTH (ADDR_WIDTH + 1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_track_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (s_mem_gnt),
        .push_data ({s_mem_we, s_mem_addr}),
        .pop       (rsp_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_op   = op_e'(fifo_head[ADDR_WIDTH]);
    assign head_addr = fifo_head[ADDR_WIDTH-1:0];

    // Only the channel matching the oldest request may complete.
    assign m_axi_rready = !fifo_empty && (head_op == READ);
    assign m_axi_bready = !fifo_empty && (head_op == WRITE);
    assign r_hs    = m_axi_rvalid && m_axi_rready;
    assign b_hs    = m_axi_bvalid && m_axi_bready;
    assign rsp_pop = r_hs || b_hs;

    // One-cycle response pulse to the core; rdata is zero unless a read returns.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_mem_valid <= 1'b0;
            s_mem_rdata <= '0;
            s_mem_error <= 1'b0;
        end else begin
            s_mem_valid <= rsp_pop;
            s_mem_rdata <= r_hs ? m_axi_rdata : '0;
            s_mem_error <= (r_hs && m_axi_rresp[1]) || (b_hs && m_axi_bresp[1]);
        end
    end

    // Response sideband the bridge has no use for (single ID, single beat).
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^{m_axi_rid, m_axi_bid, m_axi_rlast,
                               m_axi_rresp[0], m_axi_bresp[0]};

`ifdef MEM_AXI_BRIDGE_ERR_CAPTURE_EN
    logic err_hs;
    assign err_hs = (r_hs && m_axi_rresp[1]) || (b_hs && m_axi_bresp[1]);

    // Sticky first-error capture; a new error in the clear cycle re-arms it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_irq_o  <= 1'b0;
            err_addr_o <= '0;
        end else if (err_hs && (!err_irq_o || err_clr_i)) begin
            err_irq_o  <= 1'b1;
            err_addr_o <= head_addr;
        end else if (err_clr_i) begin
            err_irq_o  <= 1'b0;
            err_addr_o <= '0;
        end
    end
`else
    assign err_irq_o  = 1'b0;
    assign err_addr_o = '0;

    logic unused_err_bits;
    assign unused_err_bits = ^{err_clr_i, head_addr};
`endif

endmodule

// File: tb/tb_mem_to_axi_bridge.sv
// Directed bench for mem_to_axi_bridge. Expectations for the error-capture
// outputs follow MEM_AXI_BRIDGE_ERR_CAPTURE_EN as seen by this file.
module tb_mem_to_axi_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 6;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          s_mem_req = 1'b0;
    logic          s_mem_gnt;
    logic [AW-1:0] s_mem_addr = '0;
    logic          s_mem_we = 1'b0;
    logic [3:0]    s_mem_be = '0;
    logic [DW-1:0] s_mem_wdata = '0;
    logic          s_mem_valid;
    logic [DW-1:0] s_mem_rdata;
    logic          s_mem_error;
    logic          awvalid, awready = 1'b0;
    logic [AW-1:0] awaddr;
    logic [IW-1:0] awid;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic [3:0]    awcache;
    logic [2:0]    awprot;
    logic          awlock;
    logic [3:0]    awqos, awregion;
    logic          wvalid, wready = 1'b0;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          wlast;
    logic          bvalid = 1'b0, bready;
    logic [1:0]    bresp = 2'b00;
    logic [IW-1:0] bid = '0;
    logic          arvalid, arready = 1'b0;
    logic [AW-1:0] araddr;
    logic [IW-1:0] arid;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arlock;
    logic [3:0]    arqos, arregion;
    logic          rvalid = 1'b0, rready;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = 2'b00;
    logic [IW-1:0] rid = '0;
    logic          rlast = 1'b1;
    logic          err_irq_o;
    logic [AW-1:0] err_addr_o;
    logic          err_clr_i = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;
    int aw_cnt = 0;
    int w_cnt  = 0;
    int ar_cnt = 0;

`ifdef MEM_AXI_BRIDGE_ERR_CAPTURE_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    mem_to_axi_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_mem_req(s_mem_req), .s_mem_gnt(s_mem_gnt), .s_mem_addr(s_mem_addr),
        .s_mem_we(s_mem_we), .s_mem_be(s_mem_be), .s_mem_wdata(s_mem_wdata),
        .s_mem_valid(s_mem_valid), .s_mem_rdata(s_mem_rdata), .s_mem_error(s_mem_error),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awid(awid), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_awlock(awlock), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp), .m_axi_bid(bid),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
        .m_axi_arid(arid), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arlock(arlock), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
        .m_axi_rresp(rresp), .m_axi_rid(rid), .m_axi_rlast(rlast),
        .err_irq_o(err_irq_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
    );

    // Clock and handshake counters.
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (awvalid && awready) aw_cnt++;
        if (wvalid && wready)   w_cnt++;
        if (arvalid && arready) ar_cnt++;
    end

    // Advance one cycle; inputs are driven and outputs sampled at the negedge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        s_mem_req = 1'b1;
        #1;
        n_vec++; if (s_mem_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b exp 0", s_mem_gnt); end
        n_vec++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin n_fail++; $display("FAIL rst_valids: got %b exp 000", {arvalid, awvalid, wvalid}); end
        n_vec++; if ({s_mem_valid, s_mem_error, s_mem_rdata} !== '0) begin n_fail++; $display("FAIL rst_rsp: got %b %b %h exp 0", s_mem_valid, s_mem_error, s_mem_rdata); end
        n_vec++; if ({err_irq_o, err_addr_o} !== '0) begin n_fail++; $display("FAIL rst_err: got %b %h exp 0", err_irq_o, err_addr_o); end
        n_vec++; if ({rready, bready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b exp 00", {rready, bready}); end
        s_mem_req = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_read();
        s_mem_req = 1'b1; s_mem_we = 1'b0; s_mem_addr = 32'h8000_0010;
        #1;
        n_vec++; if (s_mem_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b exp 1", s_mem_gnt); end
        tick();
        s_mem_req = 1'b0; arready = 1'b1;
        #1;
        n_vec++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0010) begin n_fail++; $display("FAIL rd_ar: got %b %h exp 1 80000010", arvalid, araddr); end
        n_vec++; if ({arlen, arsize, arburst, arcache, arid} !== {8'd0, 3'd2, 2'b01, 4'b0011, 6'd0}) begin n_fail++; $display("FAIL rd_attr: got %h %h %h %h %h", arlen, arsize, arburst, arcache, arid); end
        n_vec++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rd_rready: got %b exp 1", rready); end
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        #1;
        n_vec++; if (arvalid !== 1'b0 || s_mem_valid !== 1'b0) begin n_fail++; $display("FAIL rd_ar_drop: got %b %b exp 0 0", arvalid, s_mem_valid); end
        tick();
        rvalid = 1'b0; rdata = '0;
        n_vec++; if (s_mem_valid !== 1'b1 || s_mem_rdata !== 32'hDEAD_BEEF || s_mem_error !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got %b %h %b exp 1 deadbeef 0", s_mem_valid, s_mem_rdata, s_mem_error); end
        tick();
        n_vec++; if (s_mem_valid !== 1'b0 || s_mem_rdata !== '0) begin n_fail++; $display("FAIL rd_pulse: got %b %h exp 0 0", s_mem_valid, s_mem_rdata); end
        n_vec++; if (ar_cnt !== 1) begin n_fail++; $display("FAIL rd_ar_count: got %0d exp 1", ar_cnt); end
    endtask

    task automatic test_write_split();
        int aw0 = aw_cnt;
        int w0  = w_cnt;
        s_mem_req = 1'b1; s_mem_we = 1'b1; s_mem_addr = 32'h1000_0004;
        s_mem_be = 4'b0011; s_mem_wdata = 32'hCAFE_F00D;
        #1;
        n_vec++; if (s_mem_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b exp 1", s_mem_gnt); end
        tick();
        s_mem_req = 1'b0; wready = 1'b1;
        #1;
        n_vec++; if ({awvalid, wvalid} !== 2'b11 || awaddr !== 32'h1000_0004) begin n_fail++; $display("FAIL wr_issue: got %b %h exp 11 10000004", {awvalid, wvalid}, awaddr); end
        n_vec++; if (wdata !== 32'hCAFE_F00D || wstrb !== 4'b0011 || wlast !== 1'b1) begin n_fail++; $display("FAIL wr_wbeat: got %h %b %b", wdata, wstrb, wlast); end
        n_vec++; if (bready !== 1'b1 || rready !== 1'b0) begin n_fail++; $display("FAIL wr_bready: got %b %b exp 1 0", bready, rready); end
        tick();
        wready = 1'b0; s_mem_req = 1'b1; s_mem_we = 1'b0; s_mem_addr = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) awready = 1'b1;
            #1;
            n_vec++; if ({awvalid, wvalid, s_mem_gnt} !== 3'b100) begin n_fail++; $display("FAIL wr_busy%0d: got %b exp 100", i, {awvalid, wvalid, s_mem_gnt}); end
            tick();
        end
        awready = 1'b0;
        #1;
        n_vec++; if ({awvalid, wvalid, s_mem_gnt} !== 3'b001) begin n_fail++; $display("FAIL wr_idle: got %b exp 001", {awvalid, wvalid, s_mem_gnt}); end
        s_mem_req = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        n_vec++; if (s_mem_valid !== 1'b1 || s_mem_error !== 1'b0 || s_mem_rdata !== '0) begin n_fail++; $display("FAIL wr_rsp: got %b %b %h exp 1 0 0", s_mem_valid, s_mem_error, s_mem_rdata); end
        n_vec++; if (aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1) begin n_fail++; $display("FAIL wr_hs_count: got %0d %0d exp 1 1", aw_cnt - aw0, w_cnt - w0); end
        tick();
    endtask

    task automatic test_fifo_full();
        arready = 1'b1; s_mem_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_mem_req = 1'b1; s_mem_addr = 32'h4000_0000 + 32'(i * 4);
            #1;
            n_vec++; if (s_mem_gnt !== 1'b1) begin n_fail++; $display("FAIL full_gnt%0d: got %b exp 1", i, s_mem_gnt); end
            tick();
            s_mem_req = 1'b0;
            tick();
        end
        s_mem_req = 1'b1; s_mem_addr = 32'h4000_0010;
        #1;
        n_vec++; if (s_mem_gnt !== 1'b0) begin n_fail++; $display("FAIL full_block: got %b exp 0", s_mem_gnt); end
        rvalid = 1'b1; rdata = 32'h0000_0011;
        tick();
        rvalid = 1'b0;
        #1;
        n_vec++; if (s_mem_gnt !== 1'b1 || s_mem_valid !== 1'b1 || s_mem_rdata !== 32'h11) begin n_fail++; $display("FAIL full_release: got %b %b %h exp 1 1 11", s_mem_gnt, s_mem_valid, s_mem_rdata); end
        s_mem_req = 1'b0;
        rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rdata = 32'h0000_0020 + 32'(i);
            tick();
            n_vec++; if (s_mem_valid !== 1'b1 || s_mem_rdata !== 32'h20 + 32'(i)) begin n_fail++; $display("FAIL full_drain%0d: got %b %h exp 1 %h", i, s_mem_valid, s_mem_rdata, 32'h20 + 32'(i)); end
        end
        rvalid = 1'b0; arready = 1'b0; rdata = '0;
        #1;
        n_vec++; if (rready !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b exp 0", rready); end
        tick();
    endtask

    task automatic test_order();
        s_mem_req = 1'b1; s_mem_we = 1'b1; s_mem_addr = 32'h0000_0200; s_mem_be = 4'hF;
        tick();
        s_mem_req = 1'b0; awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        n_vec++; if ({awvalid, wvalid} !== 2'b00) begin n_fail++; $display("FAIL ord_same_cycle: got %b exp 00", {awvalid, wvalid}); end
        s_mem_req = 1'b1; s_mem_we = 1'b0; s_mem_addr = 32'h0000_0300;
        tick();
        s_mem_req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
        #1;
        n_vec++; if ({rready, bready} !== 2'b01) begin n_fail++; $display("FAIL ord_stall: got %b exp 01", {rready, bready}); end
        tick();
        n_vec++; if (rready !== 1'b0 || s_mem_valid !== 1'b0) begin n_fail++; $display("FAIL ord_hold: got %b %b exp 0 0", rready, s_mem_valid); end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        n_vec++; if (s_mem_valid !== 1'b1 || s_mem_rdata !== '0 || rready !== 1'b1) begin n_fail++; $display("FAIL ord_b_first: got %b %h %b exp 1 0 1", s_mem_valid, s_mem_rdata, rready); end
        tick();
        rvalid = 1'b0; rdata = '0;
        n_vec++; if (s_mem_valid !== 1'b1 || s_mem_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ord_r_second: got %b %h exp 1 12345678", s_mem_valid, s_mem_rdata); end
        tick();
    endtask

    task automatic read_with_resp(input logic [AW-1:0] addr, input logic [1:0] resp);
        s_mem_req = 1'b1; s_mem_we = 1'b0; s_mem_addr = addr;
        tick();
        s_mem_req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rresp = resp;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
    endtask

    task automatic test_err_capture();
        read_with_resp(32'h2000_0000, 2'b10);
        n_vec++; if (s_mem_valid !== 1'b1 || s_mem_error !== 1'b1) begin n_fail++; $display("FAIL err_slverr: got %b %b exp 1 1", s_mem_valid, s_mem_error); end
        n_vec++; if (err_irq_o !== ERR_EN || err_addr_o !== (ERR_EN ? 32'h2000_0000 : 32'h0)) begin n_fail++; $display("FAIL err_first: got %b %h", err_irq_o, err_addr_o); end
        tick();
        read_with_resp(32'h3000_0000, 2'b11);
        n_vec++; if (s_mem_error !== 1'b1) begin n_fail++; $display("FAIL err_decerr: got %b exp 1", s_mem_error); end
        n_vec++; if (err_irq_o !== ERR_EN || err_addr_o !== (ERR_EN ? 32'h2000_0000 : 32'h0)) begin n_fail++; $display("FAIL err_sticky: got %b %h", err_irq_o, err_addr_o); end
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        n_vec++; if (err_irq_o !== 1'b0 || err_addr_o !== '0) begin n_fail++; $display("FAIL err_clear: got %b %h exp 0 0", err_irq_o, err_addr_o); end
    endtask

    task automatic test_reset_mid();
        s_mem_req = 1'b1; s_mem_we = 1'b0; s_mem_addr = 32'h4444_0000;
        tick();
        s_mem_req = 1'b0;
        #1;
        n_vec++; if (arvalid !== 1'b1 || rready !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b %b exp 1 1", arvalid, rready); end
        rst_ni = 1'b0;
        #1;
        n_vec++; if (arvalid !== 1'b0 || rready !== 1'b0) begin n_fail++; $display("FAIL mid_async: got %b %b exp 0 0", arvalid, rready); end
        tick();
        rst_ni = 1'b1;
        tick();
        n_vec++; if ({rready, bready, arvalid} !== 3'b000) begin n_fail++; $display("FAIL mid_empty: got %b exp 000", {rready, bready, arvalid}); end
        s_mem_req = 1'b1;
        #1;
        n_vec++; if (s_mem_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt: got %b exp 1", s_mem_gnt); end
        s_mem_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_split();
        test_fifo_full();
        test_order();
        test_err_capture();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_to_axi_bridge.md
MEM_TO_AXI_BRIDGE -- requirements
Module: mem_to_axi_bridge

Interface
REQ-001 Parameters, one per line: name, default, meaning. The block SHALL expose exactly these:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; legal values 32 or 64.
- ID_WIDTH, 6, AXI ID width.
- MAX_OUTSTANDING, 4, depth of the tracking FIFO; power of two, at least 2.

REQ-002 Ports, one per line: name, direction, width, meaning. The block SHALL expose exactly these; there is one clock, and reset is asynchronous and active-low:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- s_mem_req  in  1  core request.
- s_mem_gnt  out  1  request accepted.
- s_mem_addr  in  ADDR_WIDTH  request address.
- s_mem_we  in  1  1 = write.
- s_mem_be  in  DATA_WIDTH/8  byte enables.
- s_mem_wdata  in  DATA_WIDTH  write data.
- s_mem_valid  out  1  response valid.
- s_mem_rdata  out  DATA_WIDTH  read data.
- s_mem_error  out  1  response error.
- m_axi_aw{valid,ready,addr,id,len,size,burst,cache,prot,lock,qos,region}  AXI4 AW channel, standard directions and widths.
- m_axi_w{valid,ready,data,strb,last}  AXI4 W channel.
- m_axi_b{valid,ready,resp,id}  AXI4 B channel.
- m_axi_ar{valid,ready,addr,id,len,size,burst,cache,prot,lock,qos,region}  AXI4 AR channel.
- m_axi_r{valid,ready,data,resp,id,last}  AXI4 R channel.
- err_irq_o  out  1  sticky bus-error flag (macro-gated).
- err_addr_o  out  ADDR_WIDTH  address of the first failing access (macro-gated).
- err_clr_i  in  1  clears the error capture (macro-gated).

Function
REQ-003 Every AXI transfer SHALL be single-beat with fixed attributes: len 0, size log2(DATA_WIDTH/8), burst INCR (2'b01), cache 4'b0011, prot/lock/qos/region 0, id 0, wlast 1.
REQ-004 s_mem_gnt SHALL equal s_mem_req AND (issue stage idle) AND NOT (tracking FIFO full); a request is accepted in the cycle s_mem_req and s_mem_gnt are both high.
REQ-005 An accepted read SHALL drive m_axi_arvalid high from the next cycle, with the registered address, and hold it stable until m_axi_arready.
REQ-006 An accepted write SHALL drive m_axi_awvalid and m_axi_wvalid high from the next cycle; each SHALL drop independently after its own handshake, in any order, including the same cycle.
REQ-007 The issue stage SHALL be busy from acceptance until every AXI address/data handshake of that request completes; no request is accepted while it is busy.
REQ-008 On acceptance, the op type and address SHALL be pushed into the tracking FIFO.
REQ-009 Response ready SHALL follow the FIFO head: m_axi_rready = !empty && head==READ; m_axi_bready = !empty && head==WRITE.
REQ-010 A response on the channel not matching the head SHALL stall on that channel until the head matches.
REQ-011 On an R or B handshake the FIFO SHALL pop, and s_mem_valid SHALL be high for exactly the following cycle, carrying:
- s_mem_rdata = rdata (0 for writes);
- s_mem_error = resp[1].
REQ-012 Minimum read latency SHALL be 3 cycles from acceptance to s_mem_valid when arready and rvalid are both high at the earliest opportunity.
REQ-013 A push and a pop in the same cycle SHALL leave the FIFO count unchanged; FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-014 Asserting rst_ni low, at any time including mid-transaction, SHALL immediately:
- clear all valids, s_mem_gnt, s_mem_valid, s_mem_rdata, s_mem_error, err_irq_o and err_addr_o to 0;
- empty the FIFO and set the issue stage idle.
Outstanding AXI transactions SHALL be abandoned.

Configuration
REQ-015 The error capture SHALL be compiled in when macro MEM_AXI_BRIDGE_ERR_CAPTURE_EN is defined.
- With the macro: the first response with resp[1]=1 SHALL set err_irq_o and latch the FIFO-head address into err_addr_o.
- Later errors SHALL be ignored until err_clr_i is high for one cycle; an error arriving in that same cycle SHALL win.
- Without the macro: err_irq_o and err_addr_o SHALL be tied to 0, err_clr_i SHALL be ignored, and no capture logic SHALL exist.

Structure
REQ-016 A shared package mem_axi_bridge_pkg SHALL hold the op-type enum (READ/WRITE), the AXI burst/resp code constants and the fixed cache attribute.
REQ-017 The tracking FIFO SHALL be a sub-module, bridge_track_fifo, parametrised by width and depth, with full/empty outputs.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Read 0x8000_0010, arready=1, rvalid with 0xDEAD_BEEF/OKAY two cycles later -> s_mem_valid pulses once, rdata 0xDEADBEEF, error 0.
- Write 0x1000_0004, be 4'b0011; wready three cycles before awready -> one AW and one W handshake; gnt low until both complete; B OKAY -> valid, error 0.
- Four reads with rvalid held low (MAX_OUTSTANDING=4) -> s_mem_gnt low on the fifth request; one R handshake -> gnt high the next cycle.
- Write then read; bvalid held low while rvalid is already high -> rready stays 0 until the B handshake; responses delivered write first, then read.
- Macro defined, read 0x2000_0000 returning SLVERR -> s_mem_error 1, err_irq_o 1, err_addr_o 0x20000000; a second DECERR leaves err_addr_o unchanged; err_clr_i -> both cleared.
- rst_ni low while arvalid is high -> arvalid 0 in the same cycle; after release the FIFO is empty and gnt is high on the next request.
